// File: rtl/core85_busarb.sv
// HOLD/HLDA bus arbiter sharing the core85 external bus with up to NREQ requesters.
// Define BUSARB_ROUNDROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module core85_busarb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned HLDTOUT = 15,
    parameter int unsigned CNTSIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            hlda,
    output logic            hold,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            err,
    output logic [2:0]      owner
);

    typedef enum logic [2:0] {
        IDLE,
        HREQ,
        GRANT,
        HANDOVER,
        RELEASE
    } state_t;

    state_t             state;
    logic [CNTSIZE-1:0] cnt;
    logic [7:0]         req8_c;
    logic [2:0]         win_c;
    logic [NREQ-1:0]    win_onehot_c;

`ifdef BUSARB_ROUNDROBIN_EN
    logic [2:0]         ptr;
`endif

    assign req8_c       = 8'(req);
    assign win_onehot_c = NREQ'(1) << win_c;

    // Winner select: scan downward so the lowest search offset is kept last.
    always_comb begin
        logic [2:0] idx;
        win_c = '0;
        idx   = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
`ifdef BUSARB_ROUNDROBIN_EN
            idx = 3'((int'(ptr) + i) % int'(NREQ));
`else
            idx = 3'(i);
`endif
            if (req8_c[idx]) win_c = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hold  <= 1'b0;
            gnt   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
            owner <= '0;
            cnt   <= '0;
`ifdef BUSARB_ROUNDROBIN_EN
            ptr   <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        hold  <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= HREQ;
                    end
                end
                HREQ: begin
                    cnt <= cnt + CNTSIZE'(1);
                    if (!(|req)) begin
                        hold  <= 1'b0;
                        cnt   <= '0;
                        state <= RELEASE;
                    end else if (hlda) begin
                        gnt   <= win_onehot_c;
                        owner <= win_c;
`ifdef BUSARB_ROUNDROBIN_EN
                        ptr   <= 3'((int'(win_c) + 1) % int'(NREQ));
`endif
                        cnt   <= '0;
                        state <= GRANT;
                    end else if (cnt == CNTSIZE'(HLDTOUT - 1)) begin
                        err   <= 1'b1;
                        hold  <= 1'b0;
                        cnt   <= '0;
                        state <= RELEASE;
                    end
                end
                GRANT: begin
                    // A lost acknowledge is a core protocol error and outranks a normal release.
                    if (!hlda) begin
                        gnt   <= '0;
                        err   <= 1'b1;
                        hold  <= 1'b0;
                        state <= RELEASE;
                    end else if (!(|(req & gnt))) begin
                        gnt <= '0;
                        if (|(req & ~gnt)) begin
                            state <= HANDOVER;
                        end else begin
                            hold  <= 1'b0;
                            state <= RELEASE;
                        end
                    end
                end
                HANDOVER: begin
                    if (!(|req)) begin
                        hold  <= 1'b0;
                        state <= RELEASE;
                    end else begin
                        gnt   <= win_onehot_c;
                        owner <= win_c;
`ifdef BUSARB_ROUNDROBIN_EN
                        ptr   <= 3'((int'(win_c) + 1) % int'(NREQ));
`endif
                        state <= GRANT;
                    end
                end
                RELEASE: begin
                    if (!hlda) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    hold  <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core85_busarb.sv
// Self-checking bench for core85_busarb: directed scenarios plus randomized traffic
// compared every cycle against a bus-ownership model.
module tb_core85_busarb;

    localparam int NREQ    = 4;
    localparam int HLDTOUT = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            hlda = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            hold;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            err;
    logic [2:0]      owner;

    int errors = 0;
    int checks = 0;
    bit auto_core = 1'b0;
    bit auto_req  = 1'b0;

    always #5 clk = ~clk;

    core85_busarb #(.NREQ(NREQ), .HLDTOUT(HLDTOUT), .CNTSIZE(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .hlda  (hlda),
        .hold  (hold),
        .gnt   (gnt),
        .busy  (busy),
        .err   (err),
        .owner (owner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Ownership model: who holds the bus, whether we are waiting, turning around or draining.
    logic            m_hold;
    logic [NREQ-1:0] m_gnt;
    logic            m_err;
    int              m_own;
    bit              m_turn;
    bit              m_drain;
    int              m_wait;
    int              m_ptr;
    logic [NREQ-1:0] m_ob;

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int off = 0; off < NREQ; off++)
            if (r[(p + off) % NREQ]) return (p + off) % NREQ;
        return 0;
    endfunction

    task do_grant(input logic [NREQ-1:0] r);
`ifdef BUSARB_ROUNDROBIN_EN
        m_own = pick(r, m_ptr);
        m_ptr = (m_own + 1) % NREQ;
`else
        m_own = pick(r, 0);
`endif
        m_gnt = '0;
        m_gnt[m_own] = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold = 1'b0; m_gnt = '0; m_err = 1'b0; m_own = 0;
            m_turn = 1'b0; m_drain = 1'b0; m_wait = 0; m_ptr = 0;
        end else begin
            m_err = 1'b0;
            if (m_drain) begin
                if (!hlda) m_drain = 1'b0;
            end else if (m_gnt != '0) begin
                if (!hlda) begin
                    m_gnt = '0; m_hold = 1'b0; m_err = 1'b1; m_drain = 1'b1;
                end else if (!req[m_own]) begin
                    m_ob = '0;
                    m_ob[m_own] = 1'b1;
                    m_gnt = '0;
                    if ((req & ~m_ob) != '0) m_turn = 1'b1;
                    else begin m_hold = 1'b0; m_drain = 1'b1; end
                end
            end else if (m_turn) begin
                m_turn = 1'b0;
                if (req == '0) begin m_hold = 1'b0; m_drain = 1'b1; end
                else do_grant(req);
            end else if (m_hold) begin
                m_wait++;
                if (req == '0) begin m_hold = 1'b0; m_drain = 1'b1; end
                else if (hlda) do_grant(req);
                else if (m_wait == HLDTOUT) begin m_err = 1'b1; m_hold = 1'b0; m_drain = 1'b1; end
            end else if (req != '0) begin
                m_hold = 1'b1;
                m_wait = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("hold", 32'(hold), 32'(m_hold));
            check("gnt", 32'(gnt), 32'(m_gnt));
            check("busy", 32'(busy), 32'(m_hold | m_drain));
            check("err", 32'(err), 32'(m_err));
            if (m_gnt != '0) check("owner", 32'(owner), 32'(m_own));
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        end
    end

    // Randomized core: acknowledges hold after a random latency, occasionally never (timeout),
    // occasionally drops hlda mid-grant.
    int lat = 0;
    always @(negedge clk) begin
        if (auto_core) begin
            if (hold && !hlda) begin
                if (lat == 0) hlda = 1'b1;
                else lat--;
            end else if (!hold && hlda) begin
                if ($urandom_range(0, 2) == 0) hlda = 1'b0;
            end else if (gnt != '0 && hlda && $urandom_range(0, 59) == 0) begin
                hlda = 1'b0;
            end else if (!hold) begin
                lat = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
            end
        end
    end

    always @(negedge clk) begin
        if (auto_req) begin
            for (int b = 0; b < NREQ; b++) begin
                if (req[b]) begin
                    if ($urandom_range(0, 5) == 0) req[b] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req[b] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        req  = '0;
        hlda = 1'b0;
        repeat (3) tick();
    endtask

    logic [NREQ-1:0] exp_seq [3];
    logic [NREQ-1:0] g;
    int n;

    initial begin
`ifdef BUSARB_ROUNDROBIN_EN
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0001;
`else
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0001;
`endif
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_hold", 32'(hold), 32'd0);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // Single request, hlda two cycles after hold.
        req = 4'b0001;
        tick();
        check("single_hold_rise", 32'(hold), 32'd1);
        check("single_no_gnt_yet", 32'(gnt), 32'd0);
        tick();
        hlda = 1'b1;
        tick();
        check("single_gnt", 32'(gnt), 32'b0001);
        check("single_owner", 32'(owner), 32'd0);
        req = '0;
        tick();
        check("single_gnt_off", 32'(gnt), 32'd0);
        check("single_hold_off", 32'(hold), 32'd0);
        check("single_busy_release", 32'(busy), 32'd1);
        tick();
        check("single_busy_wait_hlda", 32'(busy), 32'd1);
        hlda = 1'b0;
        tick();
        check("single_busy_idle", 32'(busy), 32'd0);
        settle();

        // Abort before acknowledge.
        req = 4'b0100;
        tick();
        check("abort_hold", 32'(hold), 32'd1);
        req = '0;
        tick();
        check("abort_hold_off", 32'(hold), 32'd0);
        check("abort_no_gnt", 32'(gnt), 32'd0);
        check("abort_no_err", 32'(err), 32'd0);
        tick();
        check("abort_idle", 32'(busy), 32'd0);
        settle();

        // Timeout with hlda stuck low.
        req = 4'b0010;
        n = 0;
        do begin
            tick();
            n++;
        end while (!err && n <= 40);
        check("timeout_cycle", 32'(n), 32'd16);
        check("timeout_hold_off", 32'(hold), 32'd0);
        req = '0;
        tick();
        check("timeout_err_one_cycle", 32'(err), 32'd0);
        check("timeout_idle", 32'(busy), 32'd0);
        settle();

        // hlda lost while granted.
        req  = 4'b1000;
        hlda = 1'b1;
        tick();
        tick();
        check("hldadrop_gnt", 32'(gnt), 32'b1000);
        check("hldadrop_owner", 32'(owner), 32'd3);
        hlda = 1'b0;
        tick();
        check("hldadrop_gnt_off", 32'(gnt), 32'd0);
        check("hldadrop_err", 32'(err), 32'd1);
        req = '0;
        tick();
        check("hldadrop_err_off", 32'(err), 32'd0);
        check("hldadrop_idle", 32'(busy), 32'd0);
        settle();

        // Contention between requesters 0 and 2.
        req  = 4'b0101;
        hlda = 1'b1;
        tick();
        tick();
        g = gnt;
        for (int i = 0; i < 3; i++) begin
            check("contend_gnt", 32'(g), 32'(exp_seq[i]));
            if (i < 2) begin
                repeat (3) begin
                    tick();
                    check("contend_stable", 32'(gnt), 32'(g));
                end
                req = 4'b0101 & ~g;
                tick();
                check("contend_gap", 32'(gnt), 32'd0);
                check("contend_gap_hold", 32'(hold), 32'd1);
                req = 4'b0101;
                tick();
                g = gnt;
            end
        end
        req = '0;
        tick();
        settle();

        // Async reset mid-grant, then arbitration restarts from pointer 0.
        req  = 4'b0010;
        hlda = 1'b1;
        tick();
        tick();
        check("rst_pre_gnt", 32'(gnt), 32'b0010);
        #2 rst = 1'b1;
        #1;
        check("rst_async_hold", 32'(hold), 32'd0);
        check("rst_async_gnt", 32'(gnt), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        req = 4'b1010;
        tick();
        tick();
        check("rst_restart_gnt", 32'(gnt), 32'b0010);
        settle();

        // Randomized traffic with a mid-run reset.
        auto_core = 1'b1;
        auto_req  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        auto_req = 1'b0;
        req = '0;
        repeat (30) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core85_busarb.md
# core85_busarb

Bus arbiter that shares the core85 external address/data bus between the processor and up to NREQ DMA-style requesters using the 8085 HOLD/HLDA handshake. It sits beside core85 in the system top: it drives the core's hold input, samples hlda, and grants the bus to exactly one external requester at a time. Requesters drive the shared bus only while their grant bit is high.

## Interface
- NREQ, 4: number of external requesters (2..8)
- HLDTOUT, 15: cycles to wait for hlda after raising hold before aborting
- CNTSIZE, 4: width of the hlda-timeout counter; must satisfy 2**CNTSIZE > HLDTOUT

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- req  in  NREQ  bus request per requester; level, held high for the whole transfer
- hlda  in  1  hold acknowledge from core85
- hold  out  1  hold request to core85
- gnt  out  NREQ  one-hot bus grant; all zero when the core owns the bus
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on hlda timeout
- owner  out  3  index of the current grantee; valid only while gnt is non-zero

## Operation
- Reset (async, any state): state IDLE, hold=0, gnt=0, busy=0, err=0, owner=0, round-robin pointer=0, timeout counter=0.
- States: IDLE, HREQ, GRANT, HANDOVER, RELEASE.
- IDLE: if any req bit is high, set hold=1 and go to HREQ. The candidate is not latched yet.
- HREQ: hold=1; the counter increments each cycle.
  - hlda=1: pick the winner from the current req (see Configuration), set gnt to its one-hot, set owner, and go to GRANT. Clear the counter.
  - req drops to all-zero before hlda: drop hold and go to RELEASE.
  - Counter reaches HLDTOUT with hlda still 0: pulse err, drop hold, and go to RELEASE.
- GRANT: gnt is stable while req[owner]=1. Other requests are queued, and no preemption occurs.
  - req[owner]=0: clear gnt. If any other req is high and hlda=1, go to HANDOVER. Otherwise drop hold and go to RELEASE.
  - hlda falls while granted (core protocol error): clear gnt, pulse err, drop hold, and go to RELEASE.
- HANDOVER: one dead cycle with gnt=0 and hold=1 for bus turnaround. Next cycle, arbitrate among the current req as in HREQ.
  - req all-zero: drop hold and go to RELEASE.
  - Otherwise grant and go to GRANT.
- RELEASE: hold=0 and gnt=0. Wait for hlda=0, then go to IDLE. A new req here is not serviced until IDLE.
- The pointer updates to owner+1 (mod NREQ) on every grant.
- Invariants:
  - gnt is never non-zero unless hold=1 and hlda=1 were both sampled.
  - At most one gnt bit is high.
  - gnt is never asserted in the same cycle as a state transition into HANDOVER or RELEASE.

## Timing
- req rises in cycle n (IDLE): hold=1 from cycle n+1.
- hlda sampled high at edge m: gnt valid from edge m (registered output, visible in cycle m+1).
- Release latency: req[owner] low at edge k gives gnt=0 after edge k, and hold=0 after edge k.
- Handover: the next gnt appears two edges after the previous owner's req falls, leaving one idle cycle.
- Timeout: err is asserted on the edge where the counter equals HLDTOUT, which is HLDTOUT cycles after entering HREQ. It stays high for exactly one cycle.
- Simultaneous events:
  - req falling and hlda rising on the same edge in HREQ: the req-all-zero rule wins, so no grant is issued.
  - rst asserted mid-transfer clears gnt and hold immediately, without waiting for a clock edge.

## Configuration
- BUSARB_ROUNDROBIN_EN:
  - Defined: the winner is the first asserted req at or after the round-robin pointer, wrapping modulo NREQ.
  - Undefined: fixed priority, where the lowest asserted index wins; the pointer logic is removed and owner+1 is not tracked.

## Test plan
- Single request: req=0001 and hlda returned 2 cycles after hold → hold at +1, gnt=0001 on the hlda edge, owner=0. Dropping req gives gnt=0 and hold=0 next edge, and RELEASE lasts until hlda=0.
- Contention with round-robin: req=0101 held, each owner releasing after 3 cycles and re-requesting → gnt sequence 0001, 0100, 0001 with one idle cycle between grants. With the macro undefined, every grant goes to 0001.
- Timeout: req=0010 with hlda tied 0 → err pulses exactly 15 cycles after hold rises, hold drops, busy returns to 0.
- hlda drops during GRANT: gnt=1000 and hlda forced 0 → gnt clears next edge, err=1 for one cycle, state RELEASE then IDLE.
- Reset mid-grant: gnt=0010 and rst=1 mid-cycle → hold, gnt, and busy go to 0 without a clock edge. After rst is released, arbitration restarts with pointer=0.
- Abort before ack: req=0100 dropped while in HREQ before hlda → no gnt, hold drops next edge, no err.
